// File: rtl/mem_rr_ram_ctrl.sv
// rtl/mem_rr_ram_ctrl.sv - round-robin shared single-port RAM controller; optional MEM_PARITY_EN adds per-word parity
module mem_rr_ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        wr_valid,
    output logic [NUM_CH-1:0]        wr_ready,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        rd_valid,
    output logic [NUM_CH-1:0]        rd_ready,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH-1:0]        rd_resp_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_err
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_ch;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W:0]    idx;
    logic              grant_any;
    logic              wr_fire;
    logic              rd_fire;
    logic [NUM_CH-1:0] req;
    logic [ADDR_W-1:0] sel_wr_addr;
    logic [ADDR_W-1:0] sel_rd_addr;
    logic [DATA_W-1:0] sel_wr_data;
    logic [WORD_W-1:0] rd_word;
    logic              par_err;

    assign req = wr_valid | rd_valid;

    // Scan upward from the pointer, wrapping at NUM_CH; first requester wins.
    always_comb begin
        idx       = '0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(NUM_CH)) begin
                idx = idx - (PTR_W + 1)'(NUM_CH);
            end
            if (!grant_any && req[idx[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = idx[PTR_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_ch == PTR_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;

    // A channel with both requests presents its write; the read waits.
    always_comb begin
        wr_ready = '0;
        rd_ready = '0;
        if (reset && grant_any) begin
            if (wr_valid[grant_ch]) begin
                wr_ready[grant_ch] = 1'b1;
            end else begin
                rd_ready[grant_ch] = 1'b1;
            end
        end
    end

    assign wr_fire     = |(wr_valid & wr_ready);
    assign rd_fire     = |(rd_valid & rd_ready);
    assign sel_wr_addr = wr_addr[grant_ch*ADDR_W +: ADDR_W];
    assign sel_wr_data = wr_data[grant_ch*DATA_W +: DATA_W];
    assign sel_rd_addr = rd_addr[grant_ch*ADDR_W +: ADDR_W];
    assign rd_word     = mem[sel_rd_addr];

`ifdef MEM_PARITY_EN
    assign par_err = rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
`else
    assign par_err = 1'b0;
`endif

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
`ifdef MEM_PARITY_EN
            mem[sel_wr_addr] <= {^sel_wr_data, sel_wr_data};
`else
            mem[sel_wr_addr] <= sel_wr_data;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr           <= '0;
            rd_resp_valid <= '0;
            rd_data       <= '0;
            rd_err        <= 1'b0;
        end else begin
            rd_resp_valid <= '0;
            rd_err        <= 1'b0;
            if (grant_any) begin
                ptr <= next_ptr;
            end
            if (rd_fire) begin
                rd_resp_valid[grant_ch] <= 1'b1;
                rd_data                 <= rd_word[DATA_W-1:0];
                rd_err                  <= par_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_ram_ctrl.sv
// tb/tb_mem_rr_ram_ctrl.sv - self-checking bench for mem_rr_ram_ctrl (MEM_PARITY_EN aware)
module tb_mem_rr_ram_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NC = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [NC-1:0]  wr_valid;
    logic [NC-1:0]  wr_ready;
    logic [NC*AW-1:0] wr_addr;
    logic [NC*DW-1:0] wr_data;
    logic [NC-1:0]  rd_valid;
    logic [NC-1:0]  rd_ready;
    logic [NC*AW-1:0] rd_addr;
    logic [NC-1:0]  rd_resp_valid;
    logic [DW-1:0]  rd_data;
    logic           rd_err;

    int tests = 0;
    int fails = 0;

    mem_rr_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[c*AW +: AW] = a;
        wr_data[c*DW +: DW] = d;
    endtask

    task automatic set_rd(input int c, input logic [AW-1:0] a);
        rd_addr[c*AW +: AW] = a;
    endtask

    // Reference model: words, parity-corruption marks, pointer, pending response.
    logic [DW-1:0] m_mem [256];
    bit            m_bad [256];
    int            m_ptr = 0;
    logic [NC-1:0] exp_resp = '0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_err = 1'b0;
    logic [NC-1:0] exp_wr_rdy;
    logic [NC-1:0] exp_rd_rdy;
    int            g;
    int            c_scan;
    logic [AW-1:0] m_a;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_wr_ready", wr_ready, '0);
            check("rst_rd_ready", rd_ready, '0);
            check("rst_resp_valid", rd_resp_valid, '0);
            check("rst_rd_data", rd_data, '0);
            check("rst_rd_err", rd_err, '0);
            m_ptr    = 0;
            exp_resp = '0;
            exp_data = '0;
            exp_err  = 1'b0;
        end else begin
            check("resp_valid", rd_resp_valid, exp_resp);
            check("rd_data", rd_data, exp_data);
            check("rd_err", rd_err, exp_err);
            g = -1;
            for (int k = 0; k < NC; k++) begin
                c_scan = (m_ptr + k) % NC;
                if (g < 0 && (wr_valid[c_scan] || rd_valid[c_scan])) g = c_scan;
            end
            exp_wr_rdy = '0;
            exp_rd_rdy = '0;
            exp_resp   = '0;
            exp_err    = 1'b0;
            if (g >= 0) begin
                if (wr_valid[g]) begin
                    exp_wr_rdy[g] = 1'b1;
                    m_a = wr_addr[g*AW +: AW];
                    m_mem[m_a] = wr_data[g*DW +: DW];
                    m_bad[m_a] = 1'b0;
                end else begin
                    exp_rd_rdy[g] = 1'b1;
                    m_a = rd_addr[g*AW +: AW];
                    exp_resp[g] = 1'b1;
                    exp_data = m_mem[m_a];
                    exp_err  = m_bad[m_a];
                end
                m_ptr = (g + 1) % NC;
            end
            check("wr_ready", wr_ready, exp_wr_rdy);
            check("rd_ready", rd_ready, exp_rd_rdy);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) m_bad[i] = 1'b0;
        reset = 1'b1;
        wr_valid = '0; rd_valid = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        #1 reset = 1'b0;
        repeat (2) step();

        wr_valid = 4'b0001;
        set_wr(0, 8'h10, 32'hDEADBEEF);
        #1;
        check("lit_reset_wr_ready", wr_ready, 4'b0000);
        check("lit_reset_rd_data", rd_data, 32'h0);

        step();
        reset = 1'b1;
        #1;
        check("lit_single_wr_ready", wr_ready, 4'b0001);
        step();
        wr_valid = '0;
        rd_valid = 4'b0001;
        set_rd(0, 8'h10);
        #1;
        check("lit_single_rd_ready", rd_ready, 4'b0001);
        step();
        rd_valid = '0;
        #1;
        check("lit_single_resp", rd_resp_valid, 4'b0001);
        check("lit_single_data", rd_data, 32'hDEADBEEF);

        wr_valid = 4'b0001; set_wr(0, 8'h01, 32'h11);
        step();
        wr_valid = 4'b0010; set_wr(1, 8'h02, 32'h22);
        step();
        wr_valid = '0;
        rd_valid = 4'b0011; set_rd(0, 8'h01); set_rd(1, 8'h02);
        #1;
        check("lit_cont_rdy0", rd_ready, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) rd_valid = '0;
            #1;
            check("lit_cont_resp", rd_resp_valid, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            check("lit_cont_data", rd_data, (i % 2 == 0) ? 32'h11 : 32'h22);
            if (i < 3) check("lit_cont_rdy", rd_ready, (i % 2 == 0) ? 4'b0010 : 4'b0001);
        end

        wr_valid = 4'b0010; rd_valid = 4'b0010;
        set_wr(1, 8'h20, 32'h5); set_rd(1, 8'h20);
        #1;
        check("lit_wor_wr_ready", wr_ready, 4'b0010);
        check("lit_wor_rd_ready", rd_ready, 4'b0000);
        step();
        wr_valid = '0;
        #1;
        check("lit_wor_rd_ready2", rd_ready, 4'b0010);
        step();
        rd_valid = '0;
        #1;
        check("lit_wor_data", rd_data, 32'h5);

        rd_valid = 4'b1000; set_rd(3, 8'h01); set_rd(0, 8'h02);
        #1;
        check("lit_wrap_ch3", rd_ready, 4'b1000);
        step();
        rd_valid = 4'b1001;
        #1;
        check("lit_wrap_ch0", rd_ready, 4'b0001);
        check("lit_wrap_resp3", rd_resp_valid, 4'b1000);
        step();
        rd_valid = '0;
        #1;
        check("lit_wrap_data0", rd_data, 32'h22);

        wr_valid = 4'b0001; set_wr(0, 8'h30, 32'h1);
        step();
        wr_valid = '0;
`ifdef MEM_PARITY_EN
        dut.mem[8'h30][0] = ~dut.mem[8'h30][0];
        m_mem[8'h30] = m_mem[8'h30] ^ 32'h1;
        m_bad[8'h30] = 1'b1;
`endif
        rd_valid = 4'b0001; set_rd(0, 8'h30);
        step();
        rd_valid = '0;
        #1;
`ifdef MEM_PARITY_EN
        check("lit_par_data", rd_data, 32'h0);
        check("lit_par_err", rd_err, 1'b1);
`else
        check("lit_par_data", rd_data, 32'h1);
        check("lit_par_err", rd_err, 1'b0);
`endif

        rd_valid = 4'b0001; set_rd(0, 8'h10);
        step();
        reset = 1'b0;
        #1;
        check("lit_midrst_resp", rd_resp_valid, 4'b0000);
        check("lit_midrst_data", rd_data, 32'h0);
        step();
        reset = 1'b1;
        #1;
        check("lit_postrst_rdy", rd_ready, 4'b0001);
        step();
        rd_valid = '0;
        #1;
        check("lit_postrst_data", rd_data, 32'hDEADBEEF);

        for (int a = 8'h40; a < 8'h50; a++) begin
            wr_valid = '0;
            wr_valid[a % NC] = 1'b1;
            set_wr(a % NC, AW'(a), $urandom);
            step();
        end
        wr_valid = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = (cyc % 700 == 350) ? 1'b0 : 1'b1;
            for (int c = 0; c < NC; c++) begin
                wr_valid[c] = ($urandom % 3 == 0);
                rd_valid[c] = ($urandom % 2 == 0);
                set_wr(c, AW'(8'h40 + $urandom % 16), $urandom);
                set_rd(c, AW'(8'h40 + $urandom % 16));
            end
            step();
        end
        reset = 1'b1;
        wr_valid = '0;
        rd_valid = '0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
